// File: rtl/multich_gain_delay.sv
// multich_gain_delay
//   Multi-channel delay / gain / round / saturate stream stage.
//   Each of NCH signed channels is delayed by a programmable number of
//   accepted samples, multiplied by a per-channel signed fixed-point
//   coefficient, optionally rounded, shifted by FRAC and saturated to DW bits.
//
// Ports
//   clk, rst        clock, synchronous active-low reset
//   s_tdata/valid/ready   input stream, NCH packed DW-bit samples (ch0 in LSBs)
//   m_tdata/valid/ready   output stream, same packing
//   c               NCH packed COEFW-bit signed gains (quasi-static)
//   delay           delay in accepted samples, clamped to DEPTH
//   bypass          unity gain, no rounding/saturation; delay still applied
//   sat_flag        sticky saturation indicator
//   clr_sat         clears sat_flag (a simultaneous new clip wins)
module multich_gain_delay #(
  parameter int NCH   = 4,
  parameter int DW    = 16,
  parameter int COEFW = 18,
  parameter int FRAC  = 16,
  parameter int DEPTH = 8,
  parameter int ROUND = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NCH*DW-1:0]             s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  output logic [NCH*DW-1:0]             m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  input  logic [NCH*COEFW-1:0]          c,
  input  logic [$clog2(DEPTH+1)-1:0]    delay,
  input  logic                          bypass,
  output logic                          sat_flag,
  input  logic                          clr_sat
);

  localparam int DLW = $clog2(DEPTH+1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW  = DLW + 1;
  localparam int MW  = DW + COEFW;
  localparam int RW  = MW + 1;

  localparam logic signed [RW-1:0] SMAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SMIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC-1);

  logic en, acc;

  // Stage 1: delay line
  logic [NCH*DW-1:0] hist [DEPTH];
  logic [PW-1:0]     wr_ptr, wr_nxt, rd_idx;
  logic [DLW-1:0]    dcl;
  logic [IW-1:0]     wp_ext, rd_ext;
  logic [NCH*DW-1:0] x_sel, s1_x;
  logic              s1_v;

  // Stage 2: products
  logic [NCH*MW-1:0] prod, s2_p;
  logic [NCH*DW-1:0] s2_x;
  logic              s2_v;

  // Stage 3: scale / saturate
  logic [NCH*DW-1:0] res;
  logic              clip_any;

  // A full output register that is not being taken freezes the whole pipe.
  assign en       = !(m_tvalid && !m_tready);
  assign s_tready = en && rst;
  assign acc      = s_tvalid && s_tready;

  assign dcl    = (delay > DLW'(DEPTH)) ? DLW'(DEPTH) : delay;
  assign wr_nxt = (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);

  // (wr_ptr - d) mod DEPTH without a modulo operator.
  always_comb begin
    wp_ext = IW'(wr_ptr);
    if (wp_ext >= IW'(dcl))
      rd_ext = wp_ext - IW'(dcl);
    else
      rd_ext = wp_ext + IW'(DEPTH) - IW'(dcl);
    rd_idx = rd_ext[PW-1:0];
    x_sel  = (dcl == '0) ? s_tdata : hist[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      s1_v   <= 1'b0;
      s1_x   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) hist[PW'(i)] <= '0;
    end else if (en) begin
      s1_v <= acc;
      if (acc) begin
        s1_x         <= x_sel;
        hist[wr_ptr] <= s_tdata;
        wr_ptr       <= wr_nxt;
      end
    end
  end

  always_comb begin
    logic signed [DW-1:0]    xs;
    logic signed [COEFW-1:0] cs;
    logic signed [MW-1:0]    pr;
    prod = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      xs = s1_x[ch*DW +: DW];
      cs = c[ch*COEFW +: COEFW];
      pr = MW'(xs) * MW'(cs);
      prod[ch*MW +: MW] = pr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_v <= 1'b0;
      s2_p <= '0;
      s2_x <= '0;
    end else if (en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_p <= prod;
        s2_x <= s1_x;
      end
    end
  end

  always_comb begin
    logic signed [MW-1:0] pp;
    logic signed [RW-1:0] r;
    logic signed [RW-1:0] sh;
    res      = '0;
    clip_any = 1'b0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      pp = s2_p[ch*MW +: MW];
      r  = RW'(pp);
      if (ROUND != 0) r = r + HALF;
      sh = r >>> FRAC;
      if (bypass) begin
        res[ch*DW +: DW] = s2_x[ch*DW +: DW];
      end else if (sh > SMAX) begin
        res[ch*DW +: DW] = SMAX[DW-1:0];
        clip_any = 1'b1;
      end else if (sh < SMIN) begin
        res[ch*DW +: DW] = SMIN[DW-1:0];
        clip_any = 1'b1;
      end else begin
        res[ch*DW +: DW] = sh[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (en) begin
        m_tvalid <= s2_v;
        if (s2_v) m_tdata <= res;
      end
      if (en && s2_v && clip_any)
        sat_flag <= 1'b1;
      else if (clr_sat)
        sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multich_gain_delay.sv
module tb_multich_gain_delay;

  localparam int NCH   = 4;
  localparam int DW    = 16;
  localparam int COEFW = 18;
  localparam int FRAC  = 16;
  localparam int DEPTH = 8;
  localparam int DLW   = $clog2(DEPTH+1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NCH*DW-1:0]    s_tdata = '0;
  logic                 s_tvalid = 1'b0;
  logic                 s_tready, s_tready_r0;
  logic [NCH*DW-1:0]    m_tdata, m_tdata_r0;
  logic                 m_tvalid, m_tvalid_r0;
  logic                 m_tready = 1'b1;
  logic [NCH*COEFW-1:0] c = '0;
  logic [DLW-1:0]       delay = '0;
  logic                 bypass = 1'b0;
  logic                 sat_flag, sat_flag_r0;
  logic                 clr_sat = 1'b0;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multich_gain_delay #(.NCH(NCH), .DW(DW), .COEFW(COEFW), .FRAC(FRAC),
                       .DEPTH(DEPTH), .ROUND(1)) u_dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .c(c), .delay(delay), .bypass(bypass),
    .sat_flag(sat_flag), .clr_sat(clr_sat));

  multich_gain_delay #(.NCH(NCH), .DW(DW), .COEFW(COEFW), .FRAC(FRAC),
                       .DEPTH(DEPTH), .ROUND(0)) u_dut_r0 (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready_r0), .m_tdata(m_tdata_r0), .m_tvalid(m_tvalid_r0),
    .m_tready(m_tready), .c(c), .delay(delay), .bypass(bypass),
    .sat_flag(sat_flag_r0), .clr_sat(clr_sat));

  // ---------------- reference model ----------------
  logic [NCH*DW-1:0] hist_q[$];   // accepted beats since reset, newest last
  logic [NCH*DW-1:0] exp1_q[$];   // expected outputs, ROUND=1
  logic [NCH*DW-1:0] exp0_q[$];   // expected outputs, ROUND=0

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] x,
                                          input logic [COEFW-1:0] cc,
                                          input bit byp, input bit rnd);
    longint p;
    longint maxv;
    longint minv;
    maxv = (longint'(1) <<< (DW-1)) - 1;
    minv = -(longint'(1) <<< (DW-1));
    if (byp) return x;
    p = longint'($signed(x)) * longint'($signed(cc));
    if (rnd) p = p + (longint'(1) <<< (FRAC-1));
    p = p >>> FRAC;
    if (p > maxv) p = maxv;
    if (p < minv) p = minv;
    return p[DW-1:0];
  endfunction

  always @(negedge clk) begin : monitor
    logic [NCH*DW-1:0] xd, e1, e0;
    int d;
    if (!rst) begin
      hist_q.delete();
      exp1_q.delete();
      exp0_q.delete();
    end else begin
      if (m_tvalid && m_tready) begin
        if (exp1_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_beat: got %h, expected no output", m_tdata);
        end else begin
          e1 = exp1_q.pop_front();
          e0 = exp0_q.pop_front();
          vectors++;
          if (m_tdata !== e1) begin
            miscompares++;
            $display("FAIL stream_round1: got %h, expected %h", m_tdata, e1);
          end
          vectors++;
          if (m_tdata_r0 !== e0) begin
            miscompares++;
            $display("FAIL stream_round0: got %h, expected %h", m_tdata_r0, e0);
          end
        end
      end
      if (s_tvalid && s_tready) begin
        d = (int'(delay) > DEPTH) ? DEPTH : int'(delay);
        if (d == 0)                 xd = s_tdata;
        else if (hist_q.size() >= d) xd = hist_q[hist_q.size()-d];
        else                        xd = '0;
        hist_q.push_back(s_tdata);
        if (hist_q.size() > DEPTH) void'(hist_q.pop_front());
        for (int ch = 0; ch < NCH; ch++) begin
          e1[ch*DW +: DW] = scale(xd[ch*DW +: DW], c[ch*COEFW +: COEFW], bypass, 1'b1);
          e0[ch*DW +: DW] = scale(xd[ch*DW +: DW], c[ch*COEFW +: COEFW], bypass, 1'b0);
        end
        exp1_q.push_back(e1);
        exp0_q.push_back(e0);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [NCH*DW-1:0] rand_beat();
    logic [NCH*DW-1:0] v;
    for (int ch = 0; ch < NCH; ch++) v[ch*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_c_all(input logic [COEFW-1:0] v);
    for (int ch = 0; ch < NCH; ch++) c[ch*COEFW +: COEFW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(); rst = 1'b1;
  endtask

  task automatic send(input logic [NCH*DW-1:0] d);
    int n;
    n = 0;
    s_tdata = d; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 50) begin @(negedge clk); n++; end
    if (!s_tready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: s_tready=%b, expected 1 within 50 cycles", s_tready);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_tready = 1'b1;
    while ((exp1_q.size() != 0 || m_tvalid) && n < 100) begin tick(); n++; end
    vectors++;
    if (exp1_q.size() != 0 || m_tvalid) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp1_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; s_tvalid = 1'b1; s_tdata = rand_beat();
    repeat (3) tick();
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid: got %b, expected 0", m_tvalid); end
    vectors++; if (m_tdata !== '0) begin miscompares++; $display("FAIL reset_m_tdata: got %h, expected 0", m_tdata); end
    vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL reset_sat_flag: got %b, expected 0", sat_flag); end
    vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL reset_s_tready: got %b, expected 0", s_tready); end
    s_tvalid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_latency();
    logic [NCH*DW-1:0] b;
    delay = '0; bypass = 1'b0; set_c_all(COEFW'(1 << 16)); m_tready = 1'b1;
    b = rand_beat(); b[DW-1:0] = 16'd1;
    s_tdata = b; s_tvalid = 1'b1;
    @(negedge clk);
    vectors++; if (s_tready !== 1'b1) begin miscompares++; $display("FAIL latency_ready: got %b, expected 1", s_tready); end
    @(posedge clk); #1; s_tvalid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if (m_tvalid !== (k == 3)) begin
        miscompares++;
        $display("FAIL latency_k%0d: m_tvalid=%b, expected %b", k, m_tvalid, (k == 3));
      end
    end
    vectors++; if (m_tdata[DW-1:0] !== 16'd1) begin miscompares++; $display("FAIL latency_data: got %h, expected 0001", m_tdata[DW-1:0]); end
    @(posedge clk); #1;
    for (int i = 2; i <= 3; i++) begin
      b = rand_beat(); b[DW-1:0] = DW'(i);
      send(b);
    end
    drain();
  endtask

  task automatic test_delay();
    logic [NCH*DW-1:0] b;
    do_reset();
    delay = DLW'(3);
    for (int i = 10; i <= 20; i++) begin
      for (int ch = 0; ch < NCH; ch++) b[ch*DW +: DW] = DW'(i + 100*ch);
      send(b);
    end
    drain();
    do_reset();
    delay = DLW'(9);
    for (int i = 0; i < 12; i++) send(rand_beat());
    drain();
    for (int i = 0; i < 30; i++) begin
      delay = DLW'($urandom_range(0, 15));
      send(rand_beat());
    end
    drain();
    delay = '0;
  endtask

  task automatic test_sat();
    logic [NCH*DW-1:0] b;
    do_reset();
    delay = '0; set_c_all(COEFW'(1 << 16));
    c[COEFW-1:0] = 18'h1FFFF;
    b = '0; b[DW-1:0] = 16'h7FFF;
    send(b); drain();
    vectors++; if (m_tdata[DW-1:0] !== 16'h7FFF) begin miscompares++; $display("FAIL sat_pos_data: got %h, expected 7fff", m_tdata[DW-1:0]); end
    vectors++; if (sat_flag !== 1'b1) begin miscompares++; $display("FAIL sat_set: got %b, expected 1", sat_flag); end
    clr_sat = 1'b1; tick(); clr_sat = 1'b0;
    vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL sat_clear: got %b, expected 0", sat_flag); end
    set_c_all(COEFW'(1 << 16));
    for (int ch = 0; ch < NCH; ch++) b[ch*DW +: DW] = 16'h8000;
    send(b); drain();
    vectors++; if (m_tdata[DW-1:0] !== 16'h8000) begin miscompares++; $display("FAIL sat_min_data: got %h, expected 8000", m_tdata[DW-1:0]); end
    vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL sat_min_noclip: got %b, expected 0", sat_flag); end
    c[COEFW-1:0] = 18'h1FFFF;
    b = '0; b[DW-1:0] = 16'h8000;
    send(b);
    tick();
    clr_sat = 1'b1; tick(); clr_sat = 1'b0;
    vectors++; if (sat_flag !== 1'b1) begin miscompares++; $display("FAIL sat_set_wins: got %b, expected 1", sat_flag); end
    drain();
    clr_sat = 1'b1; tick(); clr_sat = 1'b0;
  endtask

  task automatic test_round();
    logic [NCH*DW-1:0] b;
    do_reset();
    delay = '0; set_c_all(COEFW'(1 << 15));
    b = {16'hFFFF, 16'd5, 16'hFFFD, 16'd3};
    send(b); drain();
    vectors++; if (m_tdata[DW-1:0] !== 16'd2) begin miscompares++; $display("FAIL round1_pos: got %h, expected 0002", m_tdata[DW-1:0]); end
    vectors++; if (m_tdata_r0[DW-1:0] !== 16'd1) begin miscompares++; $display("FAIL round0_pos: got %h, expected 0001", m_tdata_r0[DW-1:0]); end
    vectors++; if (m_tdata[2*DW-1:DW] !== 16'hFFFF) begin miscompares++; $display("FAIL round1_neg: got %h, expected ffff", m_tdata[2*DW-1:DW]); end
    for (int r = 0; r < 4; r++) begin
      for (int ch = 0; ch < NCH; ch++) c[ch*COEFW +: COEFW] = COEFW'($urandom);
      for (int i = 0; i < 12; i++) send(rand_beat());
      drain();
    end
    clr_sat = 1'b1; tick(); clr_sat = 1'b0;
  endtask

  task automatic test_bypass();
    bypass = 1'b1;
    set_c_all(18'h1FFFF);
    for (int i = 0; i < 15; i++) begin
      delay = DLW'($urandom_range(0, 9));
      send(rand_beat());
    end
    drain();
    vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL bypass_nosat: got %b, expected 0", sat_flag); end
    bypass = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [NCH*DW-1:0] cur, held;
    delay = DLW'(1);
    for (int ch = 0; ch < NCH; ch++) c[ch*COEFW +: COEFW] = COEFW'($urandom);
    cur = rand_beat(); held = '0;
    for (int k = 0; k < 16; k++) begin
      m_tready = !(k >= 6 && k < 11);
      s_tdata = cur; s_tvalid = 1'b1;
      @(negedge clk);
      if (k == 6) held = m_tdata;
      if (k >= 6 && k < 11) begin
        vectors++; if (s_tready !== 1'b0) begin miscompares++; $display("FAIL stall_ready_k%0d: got %b, expected 0", k, s_tready); end
        vectors++; if (m_tdata !== held) begin miscompares++; $display("FAIL stall_hold_k%0d: got %h, expected %h", k, m_tdata, held); end
      end
      if (s_tready) cur = rand_beat();
      @(posedge clk); #1;
    end
    for (int k = 0; k < 80; k++) begin
      m_tready = 1'($urandom_range(0, 1));
      s_tvalid = 1'($urandom_range(0, 1));
      s_tdata = cur;
      @(negedge clk);
      if (s_tvalid && s_tready) cur = rand_beat();
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    delay = DLW'(2); set_c_all(COEFW'(1 << 16));
    for (int i = 0; i < 5; i++) send(rand_beat());
    rst = 1'b0; tick(); rst = 1'b1;
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b, expected 0", m_tvalid); end
    vectors++; if (m_tdata !== '0) begin miscompares++; $display("FAIL midreset_data: got %h, expected 0", m_tdata); end
    for (int i = 0; i < 6; i++) send(rand_beat());
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_delay();
    test_sat();
    test_round();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/multich_gain_delay.md
Name: multich_gain_delay

Overview:
- Multi-channel successor to the single-register pass-through model.
- Each of NCH signed channels is delayed by a programmable number of accepted samples, scaled by a per-channel fixed-point coefficient, rounded and saturated.
- Streams in and out over valid/ready handshakes.
- Sits between stream sources and sinks in simulation test fixtures and DSP datapaths.

Parameters:
- NCH, 4, number of channels.
- DW, 16, signed sample width.
- COEFW, 18, signed coefficient width.
- FRAC, 16, coefficient fractional bits (1.0 = 2^FRAC); 1 <= FRAC < DW+COEFW.
- DEPTH, 8, maximum delay in samples; DEPTH >= 1.
- ROUND, 1, 1 = round-half-up before shift, 0 = truncate.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst==0 resets).
- s_tdata  in  [DW-1:0] x NCH  input samples, one per channel.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input ready.
- m_tdata  out  [DW-1:0] x NCH  output samples.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream ready.
- c  in  [COEFW-1:0] x NCH  per-channel signed gain, quasi-static.
- delay  in  $clog2(DEPTH+1)  delay in samples; values > DEPTH clamp to DEPTH.
- bypass  in  1  1 = unity gain, no rounding or saturation; delay still applied.
- sat_flag  out  1  sticky: any channel saturated.
- clr_sat  in  1  clears sat_flag.

Behaviour:
- Reset values (rst==0 at a clk edge):
  - m_tvalid=0, m_tdata all 0, sat_flag=0.
  - Write pointer = 0, all DEPTH x NCH history entries = 0.
  - All pipeline valid bits = 0.
  - s_tready=0 while rst==0.
- Reset mid-stream discards in-flight beats with no output.
- Pipeline enable: en = !(m_tvalid && !m_tready).
  - s_tready = en && rst.
  - All stages advance only when en=1; a stall freezes every stage and m_tdata holds stable.
- Acceptance: s_tvalid && s_tready.
- Stage 1 (delay), on each acceptance:
  - Read d = clamp(delay).
  - d==0: output the incoming sample.
  - Otherwise: read history[(wr_ptr - d) mod DEPTH] before writing.
  - Then write the incoming sample to history[wr_ptr]; wr_ptr increments mod DEPTH.
  - The delay value applies per accepted beat, so a change takes effect on the next acceptance. After reset, the first d outputs are 0.
- Stage 2 (multiply): p = signed(x_d) * signed(c[ch]), DW+COEFW bits, sampling c in the same cycle.
- Stage 3 (scale):
  - If ROUND=1, add 2^(FRAC-1).
  - Arithmetic right shift by FRAC.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
  - Load m_tdata and set m_tvalid.
- Bypass: stage 3 takes x_d unchanged; sat is never set.
- Latency: 3 clk from acceptance to m_tvalid with no back-pressure. Throughput: 1 beat/clk.
- m_tvalid falls after a transfer if no new beat reaches stage 3.
- sat_flag:
  - Set when any channel clips on a beat that loads the output register.
  - Cleared by clr_sat==1.
  - If set and clear happen in the same cycle, set wins.
- Bubbles: stage valids propagate. A stage holding an invalid beat does not update sat_flag or the history.

Test Plan:
- Reset release, delay=0, c=2^16 on all channels, feed 1,2,3 on ch0 -> m_tdata ch0 = 1,2,3; first m_tvalid exactly 3 clk after the first acceptance.
- delay=3, DEPTH=8, feed samples 10..20 -> outputs 0,0,0,10,11,...,17; delay=9 clamps to 8 -> first 8 outputs are 0.
- c=0x1FFFF (near 2.0), x=0x7FFF -> m_tdata=0x7FFF and sat_flag=1. x=-32768 with c=2^16 -> -32768, no sat. Then clr_sat -> sat_flag=0; clr_sat coincident with a new clip -> sat_flag remains 1.
- ROUND=1, c=2^15 (0.5), x=3 -> 2; ROUND=0 -> 1; x=-3 with ROUND=1 -> -1.
- Hold m_tready=0 for 5 clk with continuous s_tvalid -> s_tready=0 after the pipeline fills, m_tdata stable, no beats lost or duplicated after release (sequence compared end-to-end).
- Drive rst=0 for one clk mid-stream -> m_tvalid=0 the next cycle, history cleared, delay=2 then yields 0,0 before new data.
